// File: rtl/can_bit_destuff.sv
// CAN receive bit destuffer: removes stuff bits, counts them per frame, flags rule violations.
// Optional macro CAN_STUFF_ERR_EN builds the stuff-error check and the ERROR state.
module can_bit_destuff #(
    parameter int STUFF_LIMIT = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_point,
    input  logic       sampled_bit,
    input  logic       destuff_en,
    output logic       rx_bit,
    output logic       rx_bit_valid,
    output logic       remove_stuff_bit,
    output logic       stuff_err,
    output logic [7:0] stuff_cnt
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNT     = 2'd1,
        STUFF_EXP = 2'd2
`ifdef CAN_STUFF_ERR_EN
        ,
        ERROR     = 2'd3
`endif
    } state_t;

    localparam logic [2:0] LIMIT = 3'(STUFF_LIMIT);

    state_t     r_state;
    logic [2:0] r_run_len;
    logic       r_last_bit;
    logic       r_rx_bit;
    logic       r_rx_bit_valid;
    logic       r_remove_stuff_bit;
    logic [7:0] r_stuff_cnt;

    logic       w_same;
    logic [2:0] w_run_next;

    assign w_same     = (sampled_bit == r_last_bit);
    assign w_run_next = w_same ? r_run_len + 3'd1 : 3'd1;

`ifdef CAN_STUFF_ERR_EN
    logic r_stuff_err;
    assign stuff_err = r_stuff_err;
`else
    assign stuff_err = 1'b0;
`endif

    // NOTE: all state is updated with non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= IDLE;
            r_run_len          <= 3'd0;
            r_last_bit         <= 1'b1;
            r_rx_bit           <= 1'b1;
            r_rx_bit_valid     <= 1'b0;
            r_remove_stuff_bit <= 1'b0;
            r_stuff_cnt        <= 8'd0;
`ifdef CAN_STUFF_ERR_EN
            r_stuff_err        <= 1'b0;
`endif
        end else begin
            r_rx_bit_valid     <= 1'b0;
            r_remove_stuff_bit <= 1'b0;
`ifdef CAN_STUFF_ERR_EN
            r_stuff_err        <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (sample_point && destuff_en) begin
                        r_run_len      <= 3'd1;
                        r_last_bit     <= sampled_bit;
                        r_stuff_cnt    <= 8'd0;
                        r_rx_bit       <= sampled_bit;
                        r_rx_bit_valid <= 1'b1;
                        r_state        <= COUNT;
                    end
                end
                COUNT: begin
                    if (!destuff_en) begin
                        r_state   <= IDLE;
                        r_run_len <= 3'd0;
                    end else if (sample_point) begin
                        r_run_len      <= w_run_next;
                        r_last_bit     <= sampled_bit;
                        r_rx_bit       <= sampled_bit;
                        r_rx_bit_valid <= 1'b1;
                        if (w_run_next == LIMIT) r_state <= STUFF_EXP;
                    end
                end
                STUFF_EXP: begin
                    // Evaluated even after destuff_en falls: the stuff bit may follow the last CRC bit.
                    if (sample_point) begin
                        r_state    <= destuff_en ? COUNT : IDLE;
                        r_run_len  <= destuff_en ? 3'd1 : 3'd0;
                        r_last_bit <= sampled_bit;
                        if (!w_same) begin
                            r_remove_stuff_bit <= 1'b1;
                            if (r_stuff_cnt != 8'hFF) r_stuff_cnt <= r_stuff_cnt + 8'd1;
                        end else begin
`ifdef CAN_STUFF_ERR_EN
                            r_stuff_err <= 1'b1;
                            r_state     <= ERROR;
`else
                            r_rx_bit       <= sampled_bit;
                            r_rx_bit_valid <= 1'b1;
`endif
                        end
                    end
                end
`ifdef CAN_STUFF_ERR_EN
                ERROR: begin
                    if (!destuff_en) begin
                        r_state   <= IDLE;
                        r_run_len <= 3'd0;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rx_bit           = r_rx_bit;
    assign rx_bit_valid     = r_rx_bit_valid;
    assign remove_stuff_bit = r_remove_stuff_bit;
    assign stuff_cnt        = r_stuff_cnt;

endmodule

// File: tb/tb_can_bit_destuff.sv
// Self-checking bench for can_bit_destuff: directed frames plus random traffic against a
// bit-history reference model (honours CAN_STUFF_ERR_EN when defined).
module tb_can_bit_destuff;

    localparam int L = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_point = 1'b0;
    logic       sampled_bit = 1'b1;
    logic       destuff_en = 1'b0;
    logic       rx_bit;
    logic       rx_bit_valid;
    logic       remove_stuff_bit;
    logic       stuff_err;
    logic [7:0] stuff_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0 = outside frame, 1 = in frame, 2 = errored frame.
    int   m_mode = 0;
    bit   m_hist[$];
    bit   e_rx = 1'b1, e_valid = 1'b0, e_rm = 1'b0, e_err = 1'b0;
    int   e_cnt = 0;
    bit   last_sent = 1'b0;

    always #5 clk = ~clk;

    can_bit_destuff #(.STUFF_LIMIT(L)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sample_point     (sample_point),
        .sampled_bit      (sampled_bit),
        .destuff_en       (destuff_en),
        .rx_bit           (rx_bit),
        .rx_bit_valid     (rx_bit_valid),
        .remove_stuff_bit (remove_stuff_bit),
        .stuff_err        (stuff_err),
        .stuff_cnt        (stuff_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // A stuff bit is due when the last L bits seen since the last run restart are all equal.
    function automatic bit stuff_due();
        if (m_hist.size() < L) return 1'b0;
        for (int i = 1; i < L; i++)
            if (m_hist[m_hist.size() - 1 - i] != m_hist[m_hist.size() - 1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_hist.delete();
        e_rx = 1'b1; e_valid = 1'b0; e_rm = 1'b0; e_err = 1'b0; e_cnt = 0;
    endtask

    task automatic model_step(input bit sp, input bit b, input bit en);
        e_valid = 1'b0; e_rm = 1'b0; e_err = 1'b0;
        if (m_mode == 0) begin
            if (sp && en) begin
                m_hist.delete(); m_hist.push_back(b);
                e_cnt = 0; e_valid = 1'b1; e_rx = b; m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (stuff_due()) begin
                if (sp) begin
                    if (b != m_hist[m_hist.size() - 1]) begin
                        e_rm = 1'b1;
                        if (e_cnt < 255) e_cnt++;
                    end else begin
`ifdef CAN_STUFF_ERR_EN
                        e_err = 1'b1;
`else
                        e_valid = 1'b1; e_rx = b;
`endif
                    end
                    m_hist.delete(); m_hist.push_back(b);
                    if (e_err) m_mode = 2;
                    else if (!en) begin m_mode = 0; m_hist.delete(); end
                end
            end else if (!en) begin
                m_mode = 0; m_hist.delete();
            end else if (sp) begin
                m_hist.push_back(b);
                e_valid = 1'b1; e_rx = b;
            end
        end else begin
            if (!en) m_mode = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".rx_bit_valid"}, 32'(rx_bit_valid), 32'(e_valid));
        check({tag, ".remove_stuff_bit"}, 32'(remove_stuff_bit), 32'(e_rm));
        check({tag, ".stuff_err"}, 32'(stuff_err), 32'(e_err));
        check({tag, ".stuff_cnt"}, 32'(stuff_cnt), 32'(e_cnt));
        check({tag, ".rx_bit"}, 32'(rx_bit), 32'(e_rx));
    endtask

    task automatic tick(input string tag, input bit sp, input bit b, input bit en);
        sample_point = sp; sampled_bit = b; destuff_en = en;
        if (sp) last_sent = b;
        @(posedge clk);
        model_step(sp, b, en);
        #1;
        compare_all(tag);
    endtask

    task automatic mid_cycle_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0; sample_point = 1'b0; destuff_en = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Power-on reset.
        #12;
        model_reset();
        compare_all("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic destuff: 0,0,0,0,0,1(stuff),0.
        tick("basic", 1, 0, 1);
        for (int i = 0; i < 4; i++) tick("basic", 1, 0, 1);
        tick("basic_stuff", 1, 1, 1);
        check("basic_stuff_pulse", 32'(remove_stuff_bit), 32'd1);
        tick("basic", 1, 0, 1);
        check("basic_cnt", 32'(stuff_cnt), 32'd1);
        tick("basic_end", 0, 0, 0);

        // Run of equal bits at the stuff position: error (or data without the check).
        tick("err", 1, 0, 1);
        for (int i = 0; i < 6; i++) tick("err", 1, 1, 1);
        for (int i = 0; i < 3; i++) tick("err_after", 1, i[0], 1);
        tick("err_exit", 0, 0, 0);
        tick("err_exit", 0, 0, 0);

        // Final CRC bit completes a run of L, destuff_en drops, stuff bit still removed.
        tick("crc_end", 1, 0, 1);
        for (int i = 0; i < 4; i++) tick("crc_end", 1, 0, 1);
        tick("crc_end_wait", 0, 0, 0);
        tick("crc_end_wait", 0, 0, 0);
        tick("crc_end_stuff", 1, 1, 0);
        check("crc_end_pulse", 32'(remove_stuff_bit), 32'd1);
        tick("crc_end_idle", 1, 0, 0);

        // Mid-frame reset, then fresh SOF clears the counter.
        tick("rst_frame", 1, 1, 1);
        for (int i = 0; i < 5; i++) tick("rst_frame", 1, 1, 1);
        tick("rst_frame", 1, 0, 1);
        mid_cycle_reset();
        tick("rst_sof", 1, 0, 1);
        check("rst_sof_cnt", 32'(stuff_cnt), 32'd0);
        tick("rst_end", 0, 0, 0);

        // Counter saturation over 300+ stuff bits.
        tick("sat", 1, 0, 1);
        for (int i = 0; i < 1600; i++) begin
            bit b;
            b = stuff_due() ? ~m_hist[m_hist.size() - 1] : m_hist[m_hist.size() - 1];
            tick("sat", 1, b, 1);
        end
        check("sat_cnt", 32'(stuff_cnt), 32'd255);
        tick("sat_end", 0, 0, 0);
        tick("sat_end", 0, 0, 0);
        check("sat_hold", 32'(stuff_cnt), 32'd255);
        tick("sat_sof", 1, 1, 1);
        check("sat_sof_cnt", 32'(stuff_cnt), 32'd0);
        tick("sat_end", 0, 0, 0);

        // Random frames with sparse sample points and run-biased bits.
        for (int f = 0; f < 40; f++) begin
            int len;
            len = $urandom_range(10, 60);
            tick("rnd_sof", 1, $urandom_range(0, 1), 1);
            for (int i = 0; i < len; i++) begin
                bit sp, b;
                sp = ($urandom_range(0, 3) != 0);
                b  = ($urandom_range(0, 9) < 8) ? last_sent : ~last_sent;
                tick("rnd", sp, b, 1);
                if (f == 20 && i == len / 2) mid_cycle_reset();
            end
            for (int i = 0; i < 3; i++) begin
                bit sp;
                sp = ($urandom_range(0, 1) != 0);
                tick("rnd_gap", sp, ($urandom_range(0, 1) != 0) ? last_sent : ~last_sent, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/can_bit_destuff.md
CAN_BIT_DESTUFF -- requirements
Module: can_bit_destuff

Interface
REQ-001 SHALL have parameter STUFF_LIMIT, default 5, meaning the number of equal consecutive bits after which a stuff bit is expected (legal range 2..7).
REQ-002 SHALL have port clk, input, 1, the single clock. All logic is rising-edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port sample_point, input, 1, a one-cycle strobe marking a valid sampled_bit.
REQ-005 SHALL have port sampled_bit, input, 1, the bus bit sampled by the bit-timing stage.
REQ-006 SHALL have port destuff_en, input, 1, high from SOF through the last CRC bit.
REQ-007 SHALL have port rx_bit, output, 1, the destuffed data bit. It is valid only when rx_bit_valid is high.
REQ-008 SHALL have port rx_bit_valid, output, 1, a one-cycle pulse for each data (non-stuff) bit.
REQ-009 SHALL have port remove_stuff_bit, output, 1, a one-cycle pulse when the sampled bit was a stuff bit. The receiver ignores that bit.
REQ-010 SHALL have port stuff_err, output, 1, a one-cycle pulse on a stuff rule violation.
REQ-011 SHALL have port stuff_cnt, output, 8, the number of stuff bits removed in the current frame. It saturates at 255.

Function
REQ-012 SHALL process only cycles where sample_point is 1. Results appear on the outputs registered, exactly 1 clk after the sample_point cycle.
REQ-013 SHALL implement 4 states: IDLE, COUNT, STUFF_EXP, ERROR.
REQ-014 IDLE + sample_point + destuff_en=1: the bit is SOF data. Set run_len=1, last_bit=bit, clear stuff_cnt, pulse rx_bit_valid, go to COUNT.
REQ-015 COUNT + sample_point + destuff_en=1, bit equals last_bit: run_len+1. Bit differs: run_len=1, last_bit=bit. Either way pulse rx_bit_valid with rx_bit=bit.
REQ-016 COUNT: when run_len reaches STUFF_LIMIT, go to STUFF_EXP. This transition takes effect in the same update as the bit that completed the run.
REQ-017 STUFF_EXP + sample_point, bit differs from last_bit: pulse remove_stuff_bit and increment stuff_cnt (saturating). Then set run_len=1, last_bit=bit, no rx_bit_valid, and go to COUNT.
REQ-018 STUFF_EXP + sample_point, bit equals last_bit: pulse stuff_err, no rx_bit_valid, go to ERROR.
REQ-019 STUFF_EXP SHALL evaluate the next sample_point regardless of destuff_en. This covers the stuff bit that follows the final CRC bit.
REQ-020 After the STUFF_EXP check, if destuff_en=0 the state SHALL go to IDLE instead of COUNT.
REQ-021 COUNT + destuff_en=0 (at any cycle) SHALL go to IDLE, clear run_len, and produce no output pulse.
REQ-022 ERROR SHALL ignore all samples and stay in ERROR until destuff_en=0, then go to IDLE.
REQ-023 stuff_cnt SHALL hold its value in IDLE and ERROR. It clears only on the next SOF.
REQ-024 rx_bit_valid, remove_stuff_bit and stuff_err SHALL be mutually exclusive in every cycle.
REQ-025 rx_bit SHALL hold its last value when rx_bit_valid is 0.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state=IDLE, run_len=0, last_bit=1 (recessive), rx_bit=1, rx_bit_valid=0, remove_stuff_bit=0, stuff_err=0 and stuff_cnt=0.
REQ-027 A reset asserted mid-frame SHALL abort the frame. The first sample_point after release with destuff_en=1 is treated as SOF.

Configuration
REQ-028 Macro CAN_STUFF_ERR_EN, when defined, enables the stuff_err detection of REQ-018.
REQ-029 Without CAN_STUFF_ERR_EN:
- stuff_err is tied to 0.
- The ERROR state is not built.
- In STUFF_EXP an equal bit is accepted as data: pulse rx_bit_valid, set run_len=1, go to COUNT (or IDLE if destuff_en=0).

Verification
REQ-030 destuff_en=1, bits 0,0,0,0,0,1,0 -> 6 rx_bit_valid pulses (0,0,0,0,0,0) and 1 remove_stuff_bit on the 6th sample; stuff_cnt=1.
REQ-031 (CAN_STUFF_ERR_EN) bits 1,1,1,1,1,1 after SOF 0 -> stuff_err on the 7th sample 1 clk later; later samples produce no pulses; IDLE after destuff_en=0.
REQ-032 The final CRC bit completes a run of 5 and destuff_en drops in the same cycle. Next sample opposite -> remove_stuff_bit=1, then state IDLE.
REQ-033 rst_n pulsed low mid-frame between clock edges -> all outputs reach reset values immediately. The next frame's SOF is handled per REQ-014 and stuff_cnt=0.
REQ-034 STUFF_LIMIT=5: send 300 alternating 5-bit runs -> stuff_cnt saturates at 255 without wrap. The next SOF clears it to 0.
